// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC lane array.
// Widths up to MAX_W bits are handled by the generic extension and saturation helpers.
package mac_pkg;

    localparam int DEF_LANES = 3;
    localparam int DEF_ACT_W = 8;
    localparam int DEF_WGT_W = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

    // Low-order mask of w ones.
    function automatic logic [MAX_W-1:0] lowMask(input int w);
        if (w >= MAX_W) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    // Widen a srcW-bit value: sign-extend when sgn, else zero-extend.
    function automatic logic [MAX_W-1:0] extendTo(input logic [MAX_W-1:0] val, input int srcW,
                                                  input logic sgn);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] topBit;
        mask   = lowMask(srcW);
        topBit = val >> (srcW - 1);
        if (sgn && topBit[0]) return val | ~mask;
        return val & mask;
    endfunction

    // True when a+b leaves the w-bit signed (sgn) or unsigned range.
    function automatic logic addOverflows(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                          input int w, input logic sgn);
        logic [MAX_W:0]   full;
        logic [MAX_W:0]   carry;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] tA;
        logic [MAX_W-1:0] tB;
        logic [MAX_W-1:0] tS;
        mask  = lowMask(w);
        full  = {1'b0, a & mask} + {1'b0, b & mask};
        carry = full >> w;
        tA    = a >> (w - 1);
        tB    = b >> (w - 1);
        tS    = full[MAX_W-1:0] >> (w - 1);
        if (sgn) return (tA[0] == tB[0]) && (tS[0] != tA[0]);
        return carry[0];
    endfunction

    // w-bit add that clamps to the range limit on overflow.
    function automatic logic [MAX_W-1:0] satAdd(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                                input int w, input logic sgn);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] tA;
        mask = lowMask(w);
        tA   = a >> (w - 1);
        if (!addOverflows(a, b, w, sgn)) return (a + b) & mask;
        if (!sgn) return mask;
        if (tA[0]) return 64'd1 << (w - 1);
        return mask >> 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered extended product, window accumulator and output sum.
// Build option MAC_SAT_EN: sticky saturating accumulate with a per-window overflow flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int ACT_W = DEF_ACT_W,
    parameter int WGT_W = DEF_WGT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_signed,
    input  logic             i_clr,
    input  logic             i_step,
    input  logic             i_first,
    input  logic             i_close,
    input  logic [ACT_W-1:0] i_act,
    input  logic [WGT_W-1:0] i_wgt,
    output logic [ACC_W-1:0] o_psum,
    output logic             o_ovf
);

    localparam int PROD_W = ACT_W + WGT_W;

    logic signed [PROD_W-1:0] w_prodSigned;
    logic        [PROD_W-1:0] w_prodUnsigned;
    logic        [PROD_W-1:0] w_prodRaw;
    logic        [ACC_W-1:0]  w_base;
    logic        [ACC_W-1:0]  w_next;
    logic        [ACC_W-1:0]  r_prod;
    logic        [ACC_W-1:0]  r_acc;
    logic        [ACC_W-1:0]  r_psum;

    assign w_prodSigned   = PROD_W'($signed(i_act)) * PROD_W'($signed(i_wgt));
    assign w_prodUnsigned = PROD_W'(i_act) * PROD_W'(i_wgt);
    assign w_prodRaw      = i_signed ? w_prodSigned : w_prodUnsigned;
    assign w_base         = i_first ? '0 : r_acc;
    assign o_psum         = r_psum;

`ifdef MAC_SAT_EN
    logic r_tagSigned;
    logic r_ovf;
    logic r_ovfOut;
    logic w_held;
    logic w_ovfNext;

    assign w_held    = !i_first && r_ovf;
    assign w_next    = w_held ? r_acc
                              : ACC_W'(satAdd(MAX_W'(w_base), MAX_W'(r_prod), ACC_W, r_tagSigned));
    assign w_ovfNext = w_held | addOverflows(MAX_W'(w_base), MAX_W'(r_prod), ACC_W, r_tagSigned);
    assign o_ovf     = r_ovfOut;

    // Signed tag travels with the product; sticky overflow is published at window close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tagSigned <= 1'b0;
            r_ovf       <= 1'b0;
            r_ovfOut    <= 1'b0;
        end else begin
            if (i_load) r_tagSigned <= i_signed;
            if (i_clr) r_ovf <= 1'b0;
            else if (i_step) r_ovf <= i_close ? 1'b0 : w_ovfNext;
            if (i_close) r_ovfOut <= w_ovfNext;
        end
    end
`else
    assign w_next = w_base + r_prod;
    assign o_ovf  = 1'b0;
`endif

    // Stage 1 captures the extended product; stage 2 accumulates or closes into the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_psum <= '0;
        end else begin
            if (i_clr) r_prod <= '0;
            else if (i_load) r_prod <= ACC_W'(extendTo(MAX_W'(w_prodRaw), PROD_W, i_signed));
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_step) begin
                if (i_close) begin
                    r_psum <= w_next;
                    r_acc  <= '0;
                end else begin
                    r_acc <= w_next;
                end
            end
        end
    end

endmodule

// File: rtl/mac_lane_array.sv
// LANES parallel MAC lanes behind one valid/ready beat stream with a held psum output.
// Build option MAC_SAT_EN enables per-lane saturation and ovf_out.
module mac_lane_array
    import mac_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int ACT_W = DEF_ACT_W,
    parameter int WGT_W = DEF_WGT_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_signed,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*ACT_W-1:0] act_in,
    input  logic [LANES*WGT_W-1:0] wgt_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] psum_out,
    output logic [LANES-1:0]       ovf_out,
    output logic [CNT_W-1:0]       beat_cnt
);

    mac_state_e       r_state;
    logic             r_outValid;
    logic             r_pValid;
    logic             r_pLast;
    logic             r_first;
    logic [CNT_W-1:0] r_beatCnt;
    logic             w_accept;
    logic             w_clr;
    logic             w_load;
    logic             w_step;
    logic             w_close;

    assign in_ready  = (r_state == ACCUM);
    assign w_accept  = in_valid && in_ready;
    assign w_clr     = clr && (r_state != HOLD);
    assign w_load    = w_accept && !w_clr;
    assign w_step    = r_pValid && !w_clr;
    assign w_close   = w_step && r_pLast;
    assign out_valid = r_outValid;
    assign beat_cnt  = r_beatCnt;

    // Window FSM: accumulate, drain the last product, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: if (w_load && in_last) r_state <= DRAIN;
                DRAIN: begin
                    if (w_clr) begin
                        r_state <= ACCUM;
                    end else begin
                        r_state    <= HOLD;
                        r_outValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state    <= ACCUM;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // Tags riding alongside the stage-1 products, plus the window-start marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pValid <= 1'b0;
            r_pLast  <= 1'b0;
            r_first  <= 1'b1;
        end else begin
            r_pValid <= w_load;
            r_pLast  <= w_load && in_last;
            if (w_clr) r_first <= 1'b1;
            else if (w_step) r_first <= w_close;
        end
    end

    // Beats accepted in the open window, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatCnt <= '0;
        end else if (w_clr || w_close) begin
            r_beatCnt <= '0;
        end else if (w_accept && (r_beatCnt != '1)) begin
            r_beatCnt <= r_beatCnt + 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane #(
            .ACT_W(ACT_W),
            .WGT_W(WGT_W),
            .ACC_W(ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load),
            .i_signed(cfg_signed),
            .i_clr   (w_clr),
            .i_step  (w_step),
            .i_first (r_first),
            .i_close (w_close),
            .i_act   (act_in[g*ACT_W +: ACT_W]),
            .i_wgt   (wgt_in[g*WGT_W +: WGT_W]),
            .o_psum  (psum_out[g*ACC_W +: ACC_W]),
            .o_ovf   (ovf_out[g])
        );
    end

endmodule

// File: tb/tb_mac_lane_array.sv
// Self-checking bench for mac_lane_array: a 32-bit instance and a 16-bit/3-bit-counter instance
// share one stimulus stream and are checked against a window-level arithmetic model.
module tb_mac_lane_array;

    localparam int LANES = 3;
    localparam int W_A   = 32;
    localparam int W_B   = 16;
`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_signed = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] act_in = '0;
    logic [23:0] wgt_in = '0;

    logic        in_ready, out_valid, in_readyB, out_validB;
    logic [95:0] psum_out;
    logic [47:0] psumB;
    logic [2:0]  ovf_out, ovfB;
    logic [15:0] beat_cnt;
    logic [2:0]  beatB;

    int nTests = 0;
    int nFail  = 0;

    logic [23:0] qAct[$];
    logic [23:0] qWgt[$];
    bit          winSigned;

    always #5 clk = ~clk;

    mac_lane_array dut (
        .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .act_in(act_in), .wgt_in(wgt_in), .out_valid(out_valid), .out_ready(out_ready),
        .psum_out(psum_out), .ovf_out(ovf_out), .beat_cnt(beat_cnt)
    );

    mac_lane_array #(.ACC_W(W_B), .CNT_W(3)) dutB (
        .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .clr(clr),
        .in_valid(in_valid), .in_ready(in_readyB), .in_last(in_last),
        .act_in(act_in), .wgt_in(wgt_in), .out_valid(out_validB), .out_ready(out_ready),
        .psum_out(psumB), .ovf_out(ovfB), .beat_cnt(beatB)
    );

    // Window sum of one lane as plain integer arithmetic over the recorded beats.
    function automatic longint modelLane(int lane, int w, output bit ovf);
        longint mask, s, a, b, p, cur, lo, hi;
        logic [23:0] av, wv;
        mask = (longint'(1) << w) - 1;
        s = 0;
        ovf = 0;
        for (int k = 0; k < qAct.size(); k++) begin
            av = qAct[k];
            wv = qWgt[k];
            if (winSigned) begin
                a = longint'($signed(av[lane*8 +: 8]));
                b = longint'($signed(wv[lane*8 +: 8]));
            end else begin
                a = longint'(av[lane*8 +: 8]);
                b = longint'(wv[lane*8 +: 8]);
            end
            p = a * b;
            if (!SAT) begin
                s = (s + p) & mask;
            end else if (!ovf) begin
                cur = s;
                if (winSigned && s[w-1]) cur = s - (mask + 1);
                lo = winSigned ? -(longint'(1) << (w - 1)) : 0;
                hi = winSigned ? (longint'(1) << (w - 1)) - 1 : mask;
                cur = cur + p;
                if (cur > hi) begin s = hi & mask; ovf = 1; end
                else if (cur < lo) begin s = lo & mask; ovf = 1; end
                else s = cur & mask;
            end
        end
        return s;
    endfunction

    function automatic logic [95:0] modelPsum(int w, output logic [2:0] ovfv);
        logic [95:0] r;
        longint v;
        bit o;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            v = modelLane(l, w, o);
            for (int bi = 0; bi < w; bi++) r[l*w + bi] = v[bi];
            ovfv[l] = o;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic startWindow(input bit sgn);
        qAct.delete();
        qWgt.delete();
        winSigned = sgn;
    endtask

    task automatic sendBeat(input logic [23:0] a, input logic [23:0] w, input logic last, input logic sgn);
        int guard;
        guard = 0;
        in_valid = 1'b1; act_in = a; wgt_in = w; in_last = last; cfg_signed = sgn;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        if (!in_ready) begin
            nTests++; nFail++;
            $display("[TB] FAIL beat_accept: in_ready=%b required 1 within 50 cycles", in_ready);
        end else begin
            qAct.push_back(a);
            qWgt.push_back(w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        nTests++; if (psum_out !== 96'd0) begin nFail++; $display("[TB] FAIL reset_psum: got %h want 0", psum_out); end
        nTests++; if (beat_cnt !== 16'd0 || ovf_out !== 3'd0) begin nFail++; $display("[TB] FAIL reset_cnt_ovf: got %h/%b want 0/0", beat_cnt, ovf_out); end
        nTests++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_unsigned_window();
        logic [95:0] expB;
        logic [2:0] ov;
        startWindow(0);
        for (int k = 0; k < 3; k++) begin
            sendBeat(24'h030201, 24'h060504, k == 2, 1'b0);
            nTests++; if (beat_cnt !== 16'(k + 1)) begin nFail++; $display("[TB] FAIL unsigned_beat_cnt: got %0d want %0d", beat_cnt, k + 1); end
        end
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL unsigned_early_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        nTests++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL unsigned_latency: got %b want 1", out_valid); end
        nTests++; if (beat_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL unsigned_cnt_clear: got %0d want 0", beat_cnt); end
        nTests++; if (psum_out !== {32'd54, 32'd30, 32'd12}) begin nFail++; $display("[TB] FAIL unsigned_psum: got %h want 54/30/12", psum_out); end
        expB = modelPsum(W_B, ov);
        nTests++; if (psumB !== expB[47:0]) begin nFail++; $display("[TB] FAIL unsigned_psum16: got %h want %h", psumB, expB[47:0]); end
        handshake();
        nTests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL unsigned_release: got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_sign_extension();
        for (int s = 1; s >= 0; s--) begin
            startWindow(s[0]);
            sendBeat(24'h0000FF, 24'h000002, 1'b1, s[0]);
            @(posedge clk); #1;
            nTests++;
            if (psum_out !== {64'd0, (s == 1) ? 32'hFFFFFFFE : 32'h000001FE}) begin
                nFail++; $display("[TB] FAIL sign_ext signed=%0d: got %h", s, psum_out[31:0]);
            end
            nTests++;
            if (psumB !== {32'd0, (s == 1) ? 16'hFFFE : 16'h01FE}) begin
                nFail++; $display("[TB] FAIL sign_ext16 signed=%0d: got %h", s, psumB[15:0]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [95:0] expA;
        logic [2:0] ov;
        startWindow(0);
        sendBeat(24'($urandom), 24'($urandom), 1'b0, 1'b0);
        sendBeat(24'($urandom), 24'($urandom), 1'b1, 1'b0);
        expA = modelPsum(W_A, ov);
        @(posedge clk); #1;
        in_valid = 1'b1; act_in = 24'($urandom); wgt_in = 24'($urandom);
        for (int c = 0; c < 5; c++) begin
            nTests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || psum_out !== expA) begin
                nFail++; $display("[TB] FAIL hold_stable cycle %0d: valid %b ready %b psum %h want 1 0 %h", c, out_valid, in_ready, psum_out, expA);
            end
            idle(1);
        end
        in_valid = 1'b0;
        nTests++; if (beat_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL hold_no_accept: beat_cnt %0d want 0", beat_cnt); end
        out_ready = 1'b1;
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL hold_handshake_ready: got %b want 0", in_ready); end
        @(posedge clk); #1; out_ready = 1'b0;
        nTests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL hold_after: ready %b valid %b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_overflow();
        logic [95:0] expB;
        logic [2:0] ov;
        for (int s = 0; s < 2; s++) begin
            startWindow(s[0]);
            sendBeat((s == 0) ? 24'hFFFFFF : 24'h808080, (s == 0) ? 24'hFFFFFF : 24'h808080, 1'b0, s[0]);
            sendBeat((s == 0) ? 24'hFFFFFF : 24'h808080, (s == 0) ? 24'hFFFFFF : 24'h808080, 1'b1, s[0]);
            @(posedge clk); #1;
            expB = modelPsum(W_B, ov);
            if (s == 0) begin
                nTests++;
                if (psumB[15:0] !== (SAT ? 16'hFFFF : 16'hFC02) || ovfB[0] !== SAT) begin
                    nFail++; $display("[TB] FAIL ovf16_unsigned_lane0: got %h ovf %b want %h ovf %b", psumB[15:0], ovfB[0], SAT ? 16'hFFFF : 16'hFC02, SAT);
                end
            end
            nTests++; if (psumB !== expB[47:0] || ovfB !== ov) begin nFail++; $display("[TB] FAIL ovf16 signed=%0d: got %h/%b want %h/%b", s, psumB, ovfB, expB[47:0], ov); end
            nTests++; if (ovf_out !== 3'd0) begin nFail++; $display("[TB] FAIL ovf32 signed=%0d: got %b want 000", s, ovf_out); end
            handshake();
        end
    endtask

    task automatic test_clr();
        startWindow(0);
        sendBeat(24'h050505, 24'h050505, 1'b0, 1'b0);
        sendBeat(24'h050505, 24'h050505, 1'b0, 1'b0);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        nTests++; if (beat_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL clr_cnt: got %0d want 0", beat_cnt); end
        in_valid = 1'b1; clr = 1'b1; act_in = 24'h070707; wgt_in = 24'h070707;
        @(posedge clk); #1; in_valid = 1'b0; clr = 1'b0;
        startWindow(0);
        sendBeat(24'h010101, 24'h010101, 1'b1, 1'b0);
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL clr_no_early_out: got %b want 0", out_valid); end
        @(posedge clk); #1;
        nTests++; if (out_valid !== 1'b1 || psum_out !== {32'd1, 32'd1, 32'd1}) begin nFail++; $display("[TB] FAIL clr_psum: valid %b psum %h want 1 all-ones-lanes", out_valid, psum_out); end
        nTests++; if (psumB !== {16'd1, 16'd1, 16'd1}) begin nFail++; $display("[TB] FAIL clr_psum16: got %h want 000100010001", psumB); end
        handshake();
        sendBeat(24'h090909, 24'h090909, 1'b1, 1'b0);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nTests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL clr_drain cycle %0d: valid %b ready %b want 0 1", c, out_valid, in_ready); end
            idle(1);
        end
    endtask

    task automatic test_reset_in_hold();
        startWindow(0);
        sendBeat(24'h0A0B0C, 24'h0D0E0F, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        nTests++; if (out_valid !== 1'b0 || psum_out !== 96'd0 || psumB !== 48'd0) begin nFail++; $display("[TB] FAIL reset_hold_async: valid %b psum %h want 0 0", out_valid, psum_out); end
        @(posedge clk); #1; rst_n = 1'b1;
        nTests++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_hold_ready: got %b want 1", in_ready); end
        startWindow(0);
        sendBeat(24'h020202, 24'h030303, 1'b1, 1'b0);
        @(posedge clk); #1;
        nTests++; if (out_valid !== 1'b1 || psum_out !== {32'd6, 32'd6, 32'd6}) begin nFail++; $display("[TB] FAIL reset_hold_fresh: valid %b psum %h want 1 6/6/6", out_valid, psum_out); end
        handshake();
    endtask

    task automatic test_beat_cnt_saturation();
        logic [95:0] expA;
        logic [2:0] ov;
        startWindow(0);
        for (int k = 0; k < 9; k++) begin
            sendBeat(24'h010101, 24'h010101, k == 8, 1'b0);
            nTests++;
            if (beat_cnt !== 16'(k + 1) || beatB !== 3'((k + 1 > 7) ? 7 : k + 1)) begin
                nFail++; $display("[TB] FAIL beat_sat beat %0d: got %0d/%0d want %0d/%0d", k + 1, beat_cnt, beatB, k + 1, (k + 1 > 7) ? 7 : k + 1);
            end
        end
        @(posedge clk); #1;
        expA = modelPsum(W_A, ov);
        nTests++; if (psum_out !== expA || beatB !== 3'd0) begin nFail++; $display("[TB] FAIL beat_sat_close: psum %h cnt %0d want %h 0", psum_out, beatB, expA); end
        handshake();
    endtask

    task automatic test_random_windows();
        logic [95:0] expA, expB;
        logic [2:0] ovA, ovB;
        int len;
        bit sgn;
        for (int win = 0; win < 40; win++) begin
            len = $urandom_range(1, 10);
            sgn = 1'($urandom_range(0, 1));
            startWindow(sgn);
            for (int k = 0; k < len; k++) begin
                idle($urandom_range(0, 2));
                sendBeat(24'($urandom), 24'($urandom), k == len - 1, sgn);
            end
            nTests++; if (out_valid !== 1'b0 || beat_cnt !== 16'(len)) begin nFail++; $display("[TB] FAIL rand_pre win %0d: valid %b cnt %0d want 0 %0d", win, out_valid, beat_cnt, len); end
            @(posedge clk); #1;
            expA = modelPsum(W_A, ovA);
            expB = modelPsum(W_B, ovB);
            nTests++; if (out_valid !== 1'b1 || psum_out !== expA || ovf_out !== ovA) begin nFail++; $display("[TB] FAIL rand_psum win %0d: valid %b got %h/%b want %h/%b", win, out_valid, psum_out, ovf_out, expA, ovA); end
            nTests++; if (out_validB !== 1'b1 || psumB !== expB[47:0] || ovfB !== ovB) begin nFail++; $display("[TB] FAIL rand_psum16 win %0d: got %h/%b want %h/%b", win, psumB, ovfB, expB[47:0], ovB); end
            idle($urandom_range(0, 3));
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_window();
        test_sign_extension();
        test_backpressure();
        test_overflow();
        test_clr();
        test_reset_in_hold();
        test_beat_cnt_saturation();
        test_random_windows();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
